// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing pipeline (SNG front end and S2B back end).
package sc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } sc_state_e;

    // A full stream holds 2^width bits, so its length needs one bit more than the result.
    function automatic int len_w(input int width);
        return $clog2((1 << width) + 1);
    endfunction

    function automatic logic [31:0] saturate(input logic [31:0] value, input int width);
        logic [31:0] max_v;
        max_v = (32'd1 << width) - 32'd1;
        return (value > max_v) ? max_v : value;
    endfunction

endpackage

// File: rtl/sc_et_decoder_if.sv
// Bitstream input and result handshake bundle of the S2B decoder.
interface sc_et_decoder_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic             et_en;
    logic             bit_in;
    logic             bit_valid;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH:0]   len_used;

    modport slave (
        input  start, et_en, bit_in, bit_valid, out_ready,
        output busy, out_valid, result, len_used
    );

    modport master (
        output start, et_en, bit_in, bit_valid, out_ready,
        input  busy, out_valid, result, len_used
    );
endinterface

// File: rtl/sc_ckpt_est.sv
// Checkpoint detector: recognises power-of-two prefix lengths and scales the
// running count to a WIDTH-bit estimate.
module sc_ckpt_est
    import sc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int MIN_K = 2,
    parameter int KW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH:0]   len_n_i,
    input  logic [WIDTH:0]   cnt_n_i,
    output logic             is_ckpt_o,
    output logic [KW-1:0]    k_o,
    output logic [WIDTH-1:0] est_o,
    output logic             is_full_o
);

    logic [31:0] shifted;

    // Prefixes shorter than 2^MIN_K are never checkpoints; cnt <= len keeps the shift in range.
    always_comb begin
        is_ckpt_o = 1'b0;
        k_o       = '0;
        for (int i = MIN_K; i <= WIDTH; i++) begin
            if (len_n_i == ({{WIDTH{1'b0}}, 1'b1} << i)) begin
                is_ckpt_o = 1'b1;
                k_o       = KW'(i);
            end
        end
        shifted   = 32'(cnt_n_i) << (WIDTH - int'(k_o));
        est_o     = WIDTH'(saturate(shifted, WIDTH));
        is_full_o = is_ckpt_o && (int'(k_o) == WIDTH);
    end

endmodule

// File: rtl/sc_et_decoder.sv
// Stochastic-to-binary decoder with progressive-precision early termination
// and a valid/ready result port.
module sc_et_decoder
    import sc_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int MIN_K  = 2,
    parameter int ET_TOL = 0
) (
    input  logic            clk,
    input  logic            rst,
    sc_et_decoder_if.slave  bus
);

    localparam int LW = len_w(WIDTH);
    localparam int KW = $clog2(WIDTH + 1);

    sc_state_e        state_q, state_d;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic [LW-1:0]    len_q, len_d;
    logic [WIDTH-1:0] prev_est_q, prev_est_d;
    logic             et_en_q, et_en_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [LW-1:0]    len_used_q, len_used_d;

    logic [LW-1:0]    len_n;
    logic [LW-1:0]    cnt_n;
    logic             is_ckpt;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] est;
    logic             is_full;
    logic [WIDTH-1:0] est_diff;
    logic             et_hit;

    assign len_n = len_q + LW'(1);
    assign cnt_n = cnt_q + LW'(bus.bit_in);

    sc_ckpt_est #(
        .WIDTH (WIDTH),
        .MIN_K (MIN_K),
        .KW    (KW)
    ) u_ckpt (
        .len_n_i   (len_n),
        .cnt_n_i   (cnt_n),
        .is_ckpt_o (is_ckpt),
        .k_o       (k),
        .est_o     (est),
        .is_full_o (is_full)
    );

    assign est_diff = (est >= prev_est_q) ? (est - prev_est_q) : (prev_est_q - est);
    // The first checkpoint has no predecessor to agree with, hence k strictly above MIN_K.
    assign et_hit   = et_en_q && (int'(k) > MIN_K) && (int'(est_diff) <= ET_TOL);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        prev_est_d = prev_est_q;
        et_en_d    = et_en_q;
        result_d   = result_q;
        len_used_d = len_used_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = RUN;
                    cnt_d      = '0;
                    len_d      = '0;
                    prev_est_d = '0;
                    et_en_d    = bus.et_en;
                end
            end
            RUN: begin
                if (bus.start) begin
                    cnt_d      = '0;
                    len_d      = '0;
                    prev_est_d = '0;
                    et_en_d    = bus.et_en;
                end else if (bus.bit_valid) begin
                    cnt_d = cnt_n;
                    len_d = len_n;
                    if (is_ckpt) begin
                        prev_est_d = est;
                        if (is_full || et_hit) begin
                            state_d    = HOLD;
                            result_d   = est;
                            len_used_d = len_n;
                        end
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    if (bus.start) begin
                        state_d    = RUN;
                        cnt_d      = '0;
                        len_d      = '0;
                        prev_est_d = '0;
                        et_en_d    = bus.et_en;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            prev_est_q <= '0;
            et_en_q    <= 1'b0;
            result_q   <= '0;
            len_used_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            prev_est_q <= prev_est_d;
            et_en_q    <= et_en_d;
            result_q   <= result_d;
            len_used_q <= len_used_d;
        end
    end

    assign bus.busy      = (state_q == RUN);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.result    = result_q;
    assign bus.len_used  = len_used_q;

endmodule

// File: tb/tb_sc_et_decoder.sv
// Self-checking bench for sc_et_decoder: directed and random streams compared
// against a prefix-estimate reference model.
module tb_sc_et_decoder;

    localparam int WIDTH  = 8;
    localparam int MIN_K  = 2;
    localparam int ET_TOL = 0;
    localparam int FULL   = 1 << WIDTH;

    logic clk;
    logic rst;
    int   testsRun;
    int   failCount;
    bit   stream [FULL];

    sc_et_decoder_if #(.WIDTH(WIDTH)) bus ();

    sc_et_decoder #(
        .WIDTH  (WIDTH),
        .MIN_K  (MIN_K),
        .ET_TOL (ET_TOL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: walk the accepted stream, form an estimate at each 2^k prefix, stop on agreement or full length.
    function automatic void refModel(input bit et, output int expRes, output int expLen);
        int ones;
        int prev;
        int est;
        ones   = 0;
        prev   = 0;
        expRes = 0;
        expLen = 0;
        for (int n = 1; n <= FULL; n++) begin
            ones += int'(stream[n-1]);
            for (int kk = MIN_K; kk <= WIDTH; kk++) begin
                if (n == (1 << kk)) begin
                    est = ones * (1 << (WIDTH - kk));
                    if (est > FULL - 1) est = FULL - 1;
                    if (kk == WIDTH ||
                        (et && kk > MIN_K && (est > prev ? est - prev : prev - est) <= ET_TOL)) begin
                        expRes = est;
                        expLen = n;
                        return;
                    end
                    prev = est;
                end
            end
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic fillStream(input int kind, input int density);
        for (int i = 0; i < FULL; i++) begin
            case (kind)
                0:       stream[i] = 1'b1;
                1:       stream[i] = (i % 2 == 0);
                2:       stream[i] = (i < 3);
                default: stream[i] = ($urandom_range(99) < density);
            endcase
        end
    endtask

    task automatic startRun(input bit et);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.et_en     = et;
        bus.bit_valid = 1'b1;
        bus.bit_in    = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.et_en     = 1'b0;
    endtask

    task automatic feedAndCheck(input bit et, input int pct, input string tag);
        int  accepted;
        int  cycles;
        bit  bv;
        bit  lastValid;
        int  expRes;
        int  expLen;
        accepted  = 0;
        cycles    = 0;
        lastValid = 1'b0;
        while (!bus.out_valid && cycles < 4000) begin
            bv            = ($urandom_range(99) < pct);
            bus.bit_valid = bv;
            bus.bit_in    = bv ? ((accepted < FULL) ? stream[accepted] : 1'b0) : 1'($urandom);
            @(negedge clk);
            if (bv) accepted++;
            lastValid = bv;
            cycles++;
        end
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'b0;
        refModel(et, expRes, expLen);
        checkOutput({tag, "_done"},     32'(bus.out_valid), 32'd1);
        checkOutput({tag, "_latency"},  32'(lastValid),     32'd1);
        checkOutput({tag, "_busy"},     32'(bus.busy),      32'd0);
        checkOutput({tag, "_result"},   32'(bus.result),    32'(expRes));
        checkOutput({tag, "_len_used"}, 32'(bus.len_used),  32'(expLen));
        checkOutput({tag, "_consumed"}, 32'(accepted),      32'(expLen));
    endtask

    task automatic applyStimulus(input bit et, input int pct, input string tag);
        startRun(et);
        feedAndCheck(et, pct, tag);
    endtask

    task automatic releaseResult(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput({tag, "_released"}, 32'(bus.out_valid), 32'd0);
        checkOutput({tag, "_idle"},     32'(bus.busy),      32'd0);
    endtask

    task automatic holdCheck(input int cycles);
        logic [WIDTH-1:0] res0;
        logic [WIDTH:0]   len0;
        res0 = bus.result;
        len0 = bus.len_used;
        for (int i = 0; i < cycles; i++) begin
            bus.out_ready = 1'b0;
            bus.start     = 1'($urandom);
            bus.bit_valid = 1'($urandom);
            bus.bit_in    = 1'($urandom);
            @(negedge clk);
            checkOutput("hold_valid",  32'(bus.out_valid), 32'd1);
            checkOutput("hold_busy",   32'(bus.busy),      32'd0);
            checkOutput("hold_result", 32'(bus.result),    32'(res0));
            checkOutput("hold_len",    32'(bus.len_used),  32'(len0));
        end
        bus.start     = 1'b0;
        bus.bit_valid = 1'b0;
    endtask

    initial begin
        int expRes;
        int expLen;
        bit et;
        testsRun      = 0;
        failCount     = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.et_en     = 1'b0;
        bus.bit_in    = 1'b0;
        bus.bit_valid = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy",     32'(bus.busy),      32'd0);
        checkOutput("reset_valid",    32'(bus.out_valid), 32'd0);
        checkOutput("reset_result",   32'(bus.result),    32'd0);
        checkOutput("reset_len_used", 32'(bus.len_used),  32'd0);
        rst = 1'b0;

        // Bits offered in IDLE must not count.
        bus.bit_valid = 1'b1;
        bus.bit_in    = 1'b1;
        repeat (5) @(negedge clk);
        bus.bit_valid = 1'b0;

        fillStream(0, 0);
        applyStimulus(1'b0, 100, "ones");
        checkOutput("ones_const_result", 32'(bus.result),   32'd255);
        checkOutput("ones_const_len",    32'(bus.len_used), 32'd256);
        releaseResult("ones");

        fillStream(1, 0);
        applyStimulus(1'b0, 100, "alt");
        checkOutput("alt_const_result", 32'(bus.result), 32'd128);
        releaseResult("alt");

        applyStimulus(1'b1, 100, "alt_et");
        checkOutput("alt_et_const_len", 32'(bus.len_used), 32'd8);
        releaseResult("alt_et");

        fillStream(2, 0);
        applyStimulus(1'b1, 100, "decay_et");
        releaseResult("decay_et");

        fillStream(0, 0);
        applyStimulus(1'b0, 50, "ones_stall");
        holdCheck(10);
        releaseResult("ones_stall");

        startRun(1'b0);
        bus.bit_valid = 1'b1;
        bus.bit_in    = 1'b1;
        repeat (100) @(negedge clk);
        bus.bit_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("midrst_busy",   32'(bus.busy),      32'd0);
        checkOutput("midrst_valid",  32'(bus.out_valid), 32'd0);
        checkOutput("midrst_result", 32'(bus.result),    32'd0);
        checkOutput("midrst_len",    32'(bus.len_used),  32'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(1'b0, 100, "after_rst");

        // Accept the result and restart in the same cycle.
        fillStream(1, 0);
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        bus.et_en     = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        bus.et_en     = 1'b0;
        checkOutput("b2b_busy",  32'(bus.busy),      32'd1);
        checkOutput("b2b_valid", 32'(bus.out_valid), 32'd0);
        feedAndCheck(1'b1, 100, "b2b");
        releaseResult("b2b");

        for (int r = 0; r < 6; r++) begin
            fillStream(3, $urandom_range(100));
            et = 1'($urandom);
            applyStimulus(et, $urandom_range(100, 30), $sformatf("rand%0d", r));
            releaseResult($sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
